// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared types and constants for the D-PHY HS lane sequencer
package dphy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LP01,
        LP00,
        SETTLE,
        HUNT,
        ACTIVE,
        WAIT_LP11
    } lane_state_t;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_10 = 2'b10;

    localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/dphy_byte_aligner.sv
// rtl/dphy_byte_aligner.sv - sync-byte hunter and bit-offset realigner for one HS lane
module dphy_byte_aligner
    import dphy_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DPHY_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data_i,
    input  logic       hunt_en,
    input  logic       emit_en,
    output logic       lock_o,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o
);

    logic [7:0]  prev_byte;
    logic [15:0] w16;
    logic [7:0]  match;
    logic [2:0]  match_off;
    logic [2:0]  off_r;
    logic [7:0]  aligned;

    // Bit 0 of prev_byte is the oldest bit, so offset k selects a window k bits later.
    assign w16 = {byte_data_i, prev_byte};

    always_comb begin
        match = '0;
        for (int i = 0; i < 8; i++) begin
            match[i] = (w16[i +: 8] == SYNC_BYTE);
        end
    end

    // Walk downwards so the lowest matching offset wins.
    always_comb begin
        match_off = '0;
        for (int i = 7; i >= 0; i--) begin
            if (match[i]) begin
                match_off = 3'(i);
            end
        end
    end

    assign lock_o  = hunt_en && (match != '0);
    assign aligned = w16[off_r +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_byte    <= '0;
            off_r        <= '0;
            byte_data_o  <= '0;
            byte_valid_o <= 1'b0;
        end else begin
            prev_byte    <= byte_data_i;
            byte_valid_o <= emit_en;
            if (lock_o) begin
                off_r <= match_off;
            end
            if (emit_en) begin
                byte_data_o <= aligned;
            end
        end
    end

endmodule

// File: rtl/dphy_hs_lane_ctrl.sv
// rtl/dphy_hs_lane_ctrl.sv - per-lane SoT detector, HS-settle timer and sync-hunt sequencer
module dphy_hs_lane_ctrl
    import dphy_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 6,
    parameter int         SYNC_TIMEOUT  = 16,
    parameter logic [7:0] SYNC_BYTE     = DPHY_SYNC_BYTE
) (
    input  logic       byte_clk_i,
    input  logic       rst_i,
    input  logic       lp_data_p_i,
    input  logic       lp_data_n_i,
    input  logic [7:0] byte_data_i,
    output logic       hs_enable_o,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       hs_active_o,
    output logic       sync_err_o
);

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);

    logic        lp_p_meta, lp_p_sync;
    logic        lp_n_meta, lp_n_sync;
    logic [1:0]  lp;

    lane_state_t state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic        err_next;
    logic        hunt_en;
    logic        emit_en;
    logic        lock;

    // Synchronizer idles at LP-11 so reset never looks like the start of an SoT.
    always_ff @(posedge byte_clk_i) begin
        if (rst_i) begin
            lp_p_meta <= 1'b1;
            lp_p_sync <= 1'b1;
            lp_n_meta <= 1'b1;
            lp_n_sync <= 1'b1;
        end else begin
            lp_p_meta <= lp_data_p_i;
            lp_p_sync <= lp_p_meta;
            lp_n_meta <= lp_data_n_i;
            lp_n_sync <= lp_n_meta;
        end
    end

    assign lp = {lp_p_sync, lp_n_sync};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (lp == LP_01) begin
                    state_next = LP01;
                end
            end
            LP01: begin
                case (lp)
                    LP_00: state_next = LP00;
                    LP_11: state_next = IDLE;
                    LP_10: begin
                        state_next = WAIT_LP11;
                        err_next   = 1'b1;
                    end
                    default: state_next = LP01;
                endcase
            end
            LP00: begin
                cnt_next   = '0;
                state_next = (lp == LP_11) ? IDLE : SETTLE;
            end
            // LP lines are not trusted while the lane is in HS.
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = HUNT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            HUNT: begin
                if (lock) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = WAIT_LP11;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ACTIVE: begin
                if (lp == LP_11) begin
                    state_next = IDLE;
                end
            end
            WAIT_LP11: begin
                if (lp == LP_11) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hunt_en = (state == HUNT);
    // The byte seen on the LP-11 cycle is dropped so valid falls with hs_active.
    assign emit_en = (state == ACTIVE) && (state_next == ACTIVE);

    always_ff @(posedge byte_clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            hs_enable_o <= 1'b0;
            hs_active_o <= 1'b0;
            sync_err_o  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            hs_enable_o <= (state_next == SETTLE) || (state_next == HUNT) ||
                           (state_next == ACTIVE);
            hs_active_o <= (state_next == ACTIVE);
            sync_err_o  <= err_next;
        end
    end

    dphy_byte_aligner #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_aligner (
        .clk          (byte_clk_i),
        .rst          (rst_i),
        .byte_data_i  (byte_data_i),
        .hunt_en      (hunt_en),
        .emit_en      (emit_en),
        .lock_o       (lock),
        .byte_data_o  (byte_data_o),
        .byte_valid_o (byte_valid_o)
    );

endmodule

// File: tb/tb_dphy_hs_lane_ctrl.sv
// tb/tb_dphy_hs_lane_ctrl.sv - directed self-checking bench for dphy_hs_lane_ctrl
module tb_dphy_hs_lane_ctrl;
    import dphy_pkg::*;

    logic       byte_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       lp_p     = 1'b1;
    logic       lp_n     = 1'b1;
    logic [7:0] din      = 8'h00;
    logic       hs_enable;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       hs_active;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;

    always #5 byte_clk = ~byte_clk;

    dphy_hs_lane_ctrl #(
        .SETTLE_CYCLES (6),
        .SYNC_TIMEOUT  (16),
        .SYNC_BYTE     (8'hB8)
    ) dut (
        .byte_clk_i   (byte_clk),
        .rst_i        (rst),
        .lp_data_p_i  (lp_p),
        .lp_data_n_i  (lp_n),
        .byte_data_i  (din),
        .hs_enable_o  (hs_enable),
        .byte_data_o  (byte_data),
        .byte_valid_o (byte_valid),
        .hs_active_o  (hs_active),
        .sync_err_o   (sync_err)
    );

    task automatic step(input logic [1:0] lp, input logic [7:0] d);
        lp_p = lp[1];
        lp_n = lp[0];
        din  = d;
        @(posedge byte_clk);
        #1;
    endtask

    task automatic idle_lp11(input int n);
        for (int i = 0; i < n; i++) step(LP_11, 8'h00);
    endtask

    // 3 cycles of LP-01, then LP-00; ends with the FSM entering its first HUNT cycle.
    task automatic sot_preamble(input logic [7:0] last);
        for (int c = 1; c <= 13; c++) begin
            step((c <= 3) ? LP_01 : LP_00, (c == 13) ? last : 8'h00);
            checks++;
            if (hs_enable !== (c >= 7)) begin
                failures++;
                $display("FAIL sot_enable[%0d] got=%b want=%b", c, hs_enable, (c >= 7));
            end
            checks++;
            if (hs_active !== 1'b0 || byte_valid !== 1'b0) begin
                failures++;
                $display("FAIL sot_quiet[%0d] active=%b valid=%b want 0", c, hs_active, byte_valid);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(LP_11, 8'h00);
        step(LP_11, 8'h00);
        checks++;
        if ({hs_enable, byte_valid, hs_active, sync_err, byte_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got en=%b v=%b a=%b e=%b d=%h want all 0",
                     hs_enable, byte_valid, hs_active, sync_err, byte_data);
        end
        rst = 1'b0;
        idle_lp11(3);
        checks++;
        if ({hs_enable, byte_valid, hs_active, sync_err, byte_data} !== 12'h000) begin
            failures++;
            $display("FAIL post_reset_idle got en=%b v=%b a=%b e=%b d=%h want all 0",
                     hs_enable, byte_valid, hs_active, sync_err, byte_data);
        end
    endtask

    task automatic test_sot_offset0;
        logic [7:0] d [7] = '{8'hB8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        logic [1:0] l [7] = '{LP_00, LP_00, LP_00, LP_00, LP_11, LP_11, LP_11};
        logic       v [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       a [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] o [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        sot_preamble(8'h00);
        for (int i = 0; i < 7; i++) begin
            step(l[i], d[i]);
            checks++;
            if (byte_valid !== v[i]) begin
                failures++;
                $display("FAIL off0_valid[%0d] got=%b want=%b", i, byte_valid, v[i]);
            end
            checks++;
            if (hs_active !== a[i]) begin
                failures++;
                $display("FAIL off0_active[%0d] got=%b want=%b", i, hs_active, a[i]);
            end
            checks++;
            if (hs_enable !== (i < 6)) begin
                failures++;
                $display("FAIL off0_enable[%0d] got=%b want=%b", i, hs_enable, (i < 6));
            end
            if (v[i] || i == 6) begin
                checks++;
                if (byte_data !== o[i]) begin
                    failures++;
                    $display("FAIL off0_data[%0d] got=%h want=%h", i, byte_data, o[i]);
                end
            end
        end
        idle_lp11(3);
    endtask

    // Stream 00,B8,A5,5A delayed by 5 bits arrives as bytes 00,00,B7,54,0B.
    task automatic test_offset5;
        logic [7:0] d [4] = '{8'h00, 8'hB7, 8'h54, 8'h0B};
        logic       v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       a [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] o [4] = '{8'h00, 8'h00, 8'hA5, 8'h5A};
        sot_preamble(8'h00);
        for (int i = 0; i < 4; i++) begin
            step(LP_00, d[i]);
            checks++;
            if (hs_active !== a[i] || byte_valid !== v[i]) begin
                failures++;
                $display("FAIL off5_flags[%0d] active=%b valid=%b want %b %b",
                         i, hs_active, byte_valid, a[i], v[i]);
            end
            if (v[i]) begin
                checks++;
                if (byte_data !== o[i]) begin
                    failures++;
                    $display("FAIL off5_data[%0d] got=%h want=%h", i, byte_data, o[i]);
                end
            end
        end
        idle_lp11(5);
        checks++;
        if (hs_enable !== 1'b0 || byte_valid !== 1'b0 || hs_active !== 1'b0) begin
            failures++;
            $display("FAIL off5_exit en=%b v=%b a=%b want 0", hs_enable, byte_valid, hs_active);
        end
    endtask

    task automatic test_timeout;
        sot_preamble(8'h00);
        for (int i = 0; i < 17; i++) begin
            step(LP_00, 8'h00);
            checks++;
            if (sync_err !== (i == 15)) begin
                failures++;
                $display("FAIL tmo_err[%0d] got=%b want=%b", i, sync_err, (i == 15));
            end
            checks++;
            if (hs_enable !== (i < 15) || byte_valid !== 1'b0) begin
                failures++;
                $display("FAIL tmo_en[%0d] en=%b valid=%b want %b 0", i, hs_enable, byte_valid, (i < 15));
            end
        end
        for (int i = 0; i < 10; i++) begin
            step((i < 4) ? LP_01 : LP_00, 8'h00);
            checks++;
            if (hs_enable !== 1'b0 || sync_err !== 1'b0) begin
                failures++;
                $display("FAIL tmo_wait[%0d] en=%b err=%b want 0 0", i, hs_enable, sync_err);
            end
        end
        idle_lp11(4);
        sot_preamble(8'h00);
        step(LP_00, 8'hB8);
        step(LP_00, 8'h00);
        checks++;
        if (hs_active !== 1'b1) begin
            failures++;
            $display("FAIL tmo_recover got active=%b want 1", hs_active);
        end
        idle_lp11(5);
    endtask

    task automatic test_illegal_lp;
        for (int c = 1; c <= 9; c++) begin
            step((c <= 3) ? LP_01 : LP_10, 8'h00);
            checks++;
            if (sync_err !== (c == 6) || hs_enable !== 1'b0) begin
                failures++;
                $display("FAIL ill_err[%0d] err=%b en=%b want %b 0", c, sync_err, hs_enable, (c == 6));
            end
        end
        for (int c = 0; c < 4; c++) begin
            step(LP_00, 8'h00);
            checks++;
            if (hs_enable !== 1'b0) begin
                failures++;
                $display("FAIL ill_wait[%0d] en=%b want 0", c, hs_enable);
            end
        end
        idle_lp11(4);
        for (int c = 1; c <= 9; c++) begin
            step((c <= 3) ? LP_01 : LP_11, 8'h00);
            checks++;
            if (sync_err !== 1'b0 || hs_enable !== 1'b0) begin
                failures++;
                $display("FAIL abort_lp11[%0d] err=%b en=%b want 0 0", c, sync_err, hs_enable);
            end
        end
    endtask

    // B8 at bit 3 of the last settle byte: 7E3CB8<<3 -> bytes C0,E5,F1,03.
    task automatic test_settle_boundary;
        logic [7:0] d [3] = '{8'hE5, 8'hF1, 8'h03};
        logic       v [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] o [3] = '{8'h00, 8'h3C, 8'h7E};
        sot_preamble(8'hC0);
        for (int i = 0; i < 3; i++) begin
            step(LP_00, d[i]);
            checks++;
            if (hs_active !== 1'b1 || byte_valid !== v[i]) begin
                failures++;
                $display("FAIL bnd_flags[%0d] active=%b valid=%b want 1 %b", i, hs_active, byte_valid, v[i]);
            end
            if (v[i]) begin
                checks++;
                if (byte_data !== o[i]) begin
                    failures++;
                    $display("FAIL bnd_data[%0d] got=%h want=%h", i, byte_data, o[i]);
                end
            end
        end
        idle_lp11(5);
    endtask

    task automatic test_reset_mid_active;
        sot_preamble(8'h00);
        step(LP_00, 8'hB8);
        step(LP_00, 8'h11);
        step(LP_00, 8'h22);
        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h11) begin
            failures++;
            $display("FAIL rma_pre valid=%b data=%h want 1 11", byte_valid, byte_data);
        end
        rst = 1'b1;
        step(LP_00, 8'h33);
        rst = 1'b0;
        checks++;
        if ({hs_enable, byte_valid, hs_active, sync_err, byte_data} !== 12'h000) begin
            failures++;
            $display("FAIL rma_reset en=%b v=%b a=%b e=%b d=%h want all 0",
                     hs_enable, byte_valid, hs_active, sync_err, byte_data);
        end
        idle_lp11(4);
        checks++;
        if (hs_enable !== 1'b0 || byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL rma_idle en=%b v=%b want 0 0", hs_enable, byte_valid);
        end
        sot_preamble(8'h00);
        step(LP_00, 8'hB8);
        step(LP_00, 8'h5A);
        step(LP_00, 8'hC3);
        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h5A) begin
            failures++;
            $display("FAIL rma_resot0 valid=%b data=%h want 1 5a", byte_valid, byte_data);
        end
        step(LP_00, 8'h00);
        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hC3) begin
            failures++;
            $display("FAIL rma_resot1 valid=%b data=%h want 1 c3", byte_valid, byte_data);
        end
        idle_lp11(5);
    endtask

    initial begin
        test_reset();
        test_sot_offset0();
        test_offset5();
        test_timeout();
        test_illegal_lp();
        test_settle_boundary();
        test_reset_mid_active();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
